ivl_uvm_ovl_range_counter_ctrl: RTL and testbench



---
 rtl/ivl_uvm_ovl_range_counter_ctrl_pkg.sv | 27 ++
 rtl/ivl_uvm_ovl_range_counter_ctrl_rr_arb.sv | 29 ++
 rtl/ivl_uvm_ovl_range_counter_ctrl.sv | 131 +++++++++++++
 tb/tb_ivl_uvm_ovl_range_counter_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ivl_uvm_ovl_range_counter_ctrl_pkg.sv
// Shared types and the range legality rule used by the range counter controller
// and by anything that needs to predict its decisions.
package ivl_uvm_ovl_ctrl_pkg;

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic DIR_DEC = 1'b0;
    localparam logic DIR_INC = 1'b1;

    // True when applying step in direction dir keeps count inside [min_v, max_v];
    // a decrement larger than count counts as a wrap and is illegal.
    function automatic logic range_ok(input int unsigned count,
                                      input int unsigned step,
                                      input logic        dir,
                                      input int unsigned min_v,
                                      input int unsigned max_v);
        if (dir == DIR_INC) begin
            return (count + step) <= max_v;
        end
        return (step <= count) && ((count - step) >= min_v);
    endfunction

endpackage

// File: rtl/ivl_uvm_ovl_range_counter_ctrl_rr_arb.sv
// Combinational round-robin arbiter: the first requester at or after ptr wins.
module ivl_uvm_ovl_rr_arb #(
    parameter int NUM_REQ = 2,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     grant_id
);

    logic found;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req[i] && (i == ((int'(ptr) + k) % NUM_REQ))) begin
                    found    = 1'b1;
                    grant[i] = 1'b1;
                    grant_id = IDW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/ivl_uvm_ovl_range_counter_ctrl.sv
// Range-bounded shared counter: round-robin grants one inc/dec command per cycle
// and refuses any command that would leave [MIN, MAX].
module ivl_uvm_ovl_range_counter_ctrl
    import ivl_uvm_ovl_ctrl_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MIN     = 4,
    parameter int MAX     = 12,
    parameter int NUM_REQ = 2,
    parameter int STEP_W  = 2,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      clear,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_dir,
    input  logic [NUM_REQ*STEP_W-1:0] req_step,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [WIDTH-1:0]          count,
    output logic                      at_min,
    output logic                      at_max,
    output logic                      underflow_rej,
    output logic                      overflow_rej,
    output logic [IDW-1:0]            rej_id,
    output state_t                    state
);

    // Handshake: a request is presented by holding req_valid/req_dir/req_step
    // stable; it is consumed (applied or refused) in the cycle req_ready pulses.

    state_t               state_q, state_d;
    logic [IDW-1:0]       ptr_q, ptr_d;
    logic [WIDTH-1:0]     count_q, count_d;
    logic [NUM_REQ-1:0]   ready_q, ready_d;
    logic                 uf_q, uf_d, of_q, of_d;
    logic [IDW-1:0]       rej_id_q, rej_id_d;

    logic [NUM_REQ-1:0]   arb_req, grant;
    logic [IDW-1:0]       grant_id;
    logic [STEP_W-1:0]    sel_step;
    logic                 sel_dir;
    logic [WIDTH:0]       sum, diff;

    ivl_uvm_ovl_rr_arb #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_arb (
        .req      (arb_req),
        .ptr      (ptr_q),
        .grant    (grant),
        .grant_id (grant_id)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:  state_d = enable ? S_RUN : S_HOLD;
            S_RUN:   if (!enable) state_d = S_HOLD;
            S_HOLD:  if (enable) state_d = S_RUN;
            default: state_d = S_INIT;
        endcase
    end

    // Clear outranks arbitration, so requests are hidden from the arbiter.
    assign arb_req = (state_q == S_RUN && enable && !clear) ? req_valid : '0;

    always_comb begin
        sel_step = '0;
        sel_dir  = DIR_DEC;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_step = req_step[i*STEP_W +: STEP_W];
                sel_dir  = req_dir[i];
            end
        end
    end

    assign sum  = {1'b0, count_q} + (WIDTH+1)'(sel_step);
    assign diff = {1'b0, count_q} - (WIDTH+1)'(sel_step);

    always_comb begin
        count_d  = count_q;
        ready_d  = '0;
        uf_d     = 1'b0;
        of_d     = 1'b0;
        rej_id_d = '0;
        ptr_d    = ptr_q;
        if (clear && state_q != S_INIT) begin
            count_d = WIDTH'(MIN);
        end else if (|grant) begin
            ready_d = grant;
            ptr_d   = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);
            if (range_ok(32'(count_q), 32'(sel_step), sel_dir, MIN, MAX)) begin
                count_d = (sel_dir == DIR_INC) ? sum[WIDTH-1:0] : diff[WIDTH-1:0];
            end else begin
                uf_d     = (sel_dir == DIR_DEC);
                of_d     = (sel_dir == DIR_INC);
                rej_id_d = grant_id;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_INIT;
            ptr_q    <= '0;
            count_q  <= WIDTH'(MIN);
            ready_q  <= '0;
            uf_q     <= 1'b0;
            of_q     <= 1'b0;
            rej_id_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
            uf_q     <= uf_d;
            of_q     <= of_d;
            rej_id_q <= rej_id_d;
        end
    end

    assign req_ready     = ready_q;
    assign count         = count_q;
    assign at_min        = (count_q == WIDTH'(MIN));
    assign at_max        = (count_q == WIDTH'(MAX));
    assign underflow_rej = uf_q;
    assign overflow_rej  = of_q;
    assign rej_id        = rej_id_q;
    assign state         = state_q;

endmodule

// File: tb/tb_ivl_uvm_ovl_range_counter_ctrl.sv
// Directed and random stimulus for the range counter controller, checked against
// a cycle model through an expected-value queue plus literal spot checks.
module tb_ivl_uvm_ovl_range_counter_ctrl;
    import ivl_uvm_ovl_ctrl_pkg::*;

    localparam int WIDTH   = 4;
    localparam int MIN     = 4;
    localparam int MAX     = 12;
    localparam int NUM_REQ = 2;
    localparam int STEP_W  = 2;
    localparam int IDW     = $clog2(NUM_REQ);
    localparam int W       = 2 + NUM_REQ + WIDTH + 4 + IDW;

    logic                      clock = 1'b0;
    logic                      reset, enable, clear;
    logic [NUM_REQ-1:0]        req_valid, req_dir;
    logic [NUM_REQ*STEP_W-1:0] req_step;
    logic [NUM_REQ-1:0]        req_ready;
    logic [WIDTH-1:0]          count;
    logic                      at_min, at_max, underflow_rej, overflow_rej;
    logic [IDW-1:0]            rej_id;
    state_t                    state;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];

    state_t m_state = S_INIT;
    int     m_count = MIN;
    int     m_ptr   = 0;

    ivl_uvm_ovl_range_counter_ctrl #(
        .WIDTH(WIDTH), .MIN(MIN), .MAX(MAX), .NUM_REQ(NUM_REQ), .STEP_W(STEP_W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .clear         (clear),
        .req_valid     (req_valid),
        .req_dir       (req_dir),
        .req_step      (req_step),
        .req_ready     (req_ready),
        .count         (count),
        .at_min        (at_min),
        .at_max        (at_max),
        .underflow_rej (underflow_rej),
        .overflow_rej  (overflow_rej),
        .rej_id        (rej_id),
        .state         (state)
    );

    always #5 clock = ~clock;

    // Stand-in for the no_underflow/no_overflow OVL pair on count.
    always @(negedge clock) begin
        if (!reset) begin
            checks++;
            assert (count >= WIDTH'(MIN) && count <= WIDTH'(MAX)) else begin
                errors++;
                $error("FAIL ovl_range observed=%0d required=[%0d,%0d]", count, MIN, MAX);
            end
        end
    end

    task automatic check(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Predict the outputs of the coming edge, push them, clock, then compare.
    task automatic step();
        logic [NUM_REQ-1:0] e_ready;
        logic               e_uf, e_of;
        int                 e_id, g, idx, st;
        logic               d;
        state_t             n_state;
        logic [W-1:0]       expv, obs;
        e_ready = '0; e_uf = 1'b0; e_of = 1'b0; e_id = 0;
        if (reset) begin
            m_state = S_INIT; m_count = MIN; m_ptr = 0;
        end else begin
            case (m_state)
                S_INIT:  n_state = enable ? S_RUN : S_HOLD;
                S_RUN:   n_state = enable ? S_RUN : S_HOLD;
                default: n_state = enable ? S_RUN : S_HOLD;
            endcase
            if (m_state != S_INIT && clear) begin
                m_count = MIN;
            end else if (m_state == S_RUN && enable) begin
                g = -1;
                for (int k = 0; k < NUM_REQ; k++) begin
                    idx = (m_ptr + k) % NUM_REQ;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
                if (g >= 0) begin
                    e_ready[g] = 1'b1;
                    m_ptr = (g + 1) % NUM_REQ;
                    st = int'(req_step[g*STEP_W +: STEP_W]);
                    d  = req_dir[g];
                    if (range_ok(m_count, st, d, MIN, MAX)) begin
                        m_count = d ? m_count + st : m_count - st;
                    end else begin
                        e_uf = !d; e_of = d; e_id = g;
                    end
                end
            end
            m_state = n_state;
        end
        exp_q.push_back({m_state, e_ready, WIDTH'(m_count), m_count == MIN, m_count == MAX,
                         e_uf, e_of, IDW'(e_id)});
        @(posedge clock);
        #1;
        expv = exp_q.pop_front();
        obs  = {state, req_ready, count, at_min, at_max, underflow_rej, overflow_rej,
                (underflow_rej | overflow_rej) ? rej_id : IDW'(0)};
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL sb_cycle t=%0t observed=%h expected=%h", $time, obs, expv);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic d, input int st);
        req_valid[i] = v;
        req_dir[i]   = d;
        req_step[i*STEP_W +: STEP_W] = STEP_W'(st);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; clear = 1'b0;
        req_valid = '0; req_dir = '0; req_step = '0;
        step(); step();
        check("rst_count", int'(count), 4);
        check("rst_at_min", int'(at_min), 1);
        check("rst_at_max", int'(at_max), 0);
        check("rst_ready", int'(req_ready), 0);
        check("rst_rej", int'({underflow_rej, overflow_rej}), 0);
        check("rst_rej_id", int'(rej_id), 0);
        check("rst_state", int'(state), int'(S_INIT));

        // S_INIT cycle ignores a pending request.
        reset = 1'b0;
        set_req(0, 1'b1, DIR_INC, 1);
        step();
        check("init_ready", int'(req_ready), 0);
        check("init_count", int'(count), 4);
        set_req(0, 1'b0, DIR_INC, 1);
        step();
        check("edge2_count", int'(count), 4);
        check("edge2_at_min", int'(at_min), 1);

        // Count up to MAX, then one refused increment.
        set_req(0, 1'b1, DIR_INC, 1);
        for (int k = 1; k <= 8; k++) begin
            step();
            check("inc_count", int'(count), 4 + k);
            check("inc_ready", int'(req_ready), 1);
        end
        check("inc_at_max", int'(at_max), 1);
        step();
        check("ovf_flag", int'(overflow_rej), 1);
        check("ovf_id", int'(rej_id), 0);
        check("ovf_count", int'(count), 12);
        check("ovf_ready", int'(req_ready), 1);

        // Clear, go to 6, land on MIN, then underflow from requester 1.
        set_req(0, 1'b0, DIR_INC, 1);
        clear = 1'b1; step(); clear = 1'b0;
        check("clr_count", int'(count), 4);
        set_req(0, 1'b1, DIR_INC, 2); step(); set_req(0, 1'b0, DIR_INC, 2);
        check("to6_count", int'(count), 6);
        set_req(1, 1'b1, DIR_DEC, 2); step();
        check("dec_to_min", int'(count), 4);
        set_req(1, 1'b1, DIR_DEC, 1); step(); set_req(1, 1'b0, DIR_DEC, 1);
        check("udf_flag", int'(underflow_rej), 1);
        check("udf_id", int'(rej_id), 1);
        check("udf_count", int'(count), 4);

        // Reach 8 leaving the pointer at 0, then alternate two requesters.
        set_req(0, 1'b1, DIR_INC, 3); step(); set_req(0, 1'b0, DIR_INC, 3);
        set_req(1, 1'b1, DIR_INC, 1); step();
        check("to8_count", int'(count), 8);
        set_req(0, 1'b1, DIR_INC, 1);
        set_req(1, 1'b1, DIR_DEC, 1);
        for (int k = 0; k < 4; k++) begin
            step();
            check("rr_grant", int'(req_ready), (k % 2 == 0) ? 1 : 2);
            check("rr_count", int'(count), (k % 2 == 0) ? 9 : 8);
        end
        set_req(1, 1'b0, DIR_DEC, 1);

        // Hold with a pending request, then resume.
        enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("hold_ready", int'(req_ready), 0);
            check("hold_count", int'(count), 8);
        end
        enable = 1'b1;
        step();
        check("resume_first_ready", int'(req_ready), 0);
        step();
        check("resume_grant", int'(req_ready), 1);
        check("resume_count", int'(count), 9);

        // Clear wins over a simultaneous grant.
        step();
        check("to10_count", int'(count), 10);
        set_req(0, 1'b1, DIR_INC, 2);
        clear = 1'b1; step(); clear = 1'b0;
        check("clr_pri_count", int'(count), 4);
        check("clr_pri_ready", int'(req_ready), 0);
        step(); set_req(0, 1'b0, DIR_INC, 2);
        check("after_clr_count", int'(count), 6);

        // Zero step is consumed without change or refusal.
        set_req(1, 1'b1, DIR_DEC, 0); step(); set_req(1, 1'b0, DIR_DEC, 0);
        check("zero_ready", int'(req_ready), 2);
        check("zero_count", int'(count), 6);
        check("zero_rej", int'({underflow_rej, overflow_rej}), 0);

        // Reset in flight drops the request.
        set_req(0, 1'b1, DIR_INC, 1);
        reset = 1'b1; step(); reset = 1'b0;
        check("midrst_ready", int'(req_ready), 0);
        check("midrst_count", int'(count), 4);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            reset     = ($urandom_range(0, 99) == 0);
            enable    = ($urandom_range(0, 7) != 0);
            clear     = ($urandom_range(0, 15) == 0);
            req_valid = NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1));
            req_dir   = NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1));
            req_step  = (NUM_REQ*STEP_W)'($urandom_range(0, (1 << (NUM_REQ*STEP_W)) - 1));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
